// File: rtl/whackamole_game_ctrl.sv
// Whack-a-mole game logic: picks LFSR-driven mole holes, times them, judges whacks and keeps a
// two-digit BCD score for vga_display. Define MISS_PENALTY_EN to make wrong whacks cost a point.
module whackamole_game_ctrl #(
  parameter int unsigned MOLE_TICKS  = 50,
  parameter int unsigned FLASH_TICKS = 10,
  parameter int unsigned ROUNDS      = 30,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       whack_valid,
  input  logic [2:0] whack_pos,
  output logic [2:0] mole_position,
  output logic       mole_visible,
  output logic       guess_correct,
  output logic       guess_wrong,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic       game_over
);

  typedef enum logic [2:0] {StIdle, StUp, StHit, StMiss, StDone} state_e;

  localparam logic [7:0] SeedEff   = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [7:0] MoleLast  = 8'(MOLE_TICKS - 1);
  localparam logic [7:0] FlashLast = 8'(FLASH_TICKS - 1);
  localparam logic [7:0] RoundsMax = 8'(ROUNDS);

  state_e      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [2:0]  mole_q, mole_d;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  round_q, round_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        visible_q, visible_d;
  logic        correct_q, correct_d;
  logic        wrong_q, wrong_d;
  logic        over_q, over_d;

  logic [2:0]  cand;
  logic [2:0]  new_mole;
  logic [3:0]  inc_tens, inc_ones;
  logic [3:0]  dec_tens, dec_ones;

  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cand     = lfsr_q[2:0];
  // Bump a repeated hole to its neighbour so the same hole never comes up twice in a row.
  assign new_mole = (cand == mole_q) ? cand + 3'd1 : cand;

  always_comb begin
    inc_tens = tens_q;
    inc_ones = ones_q;
    if (ones_q != 4'd9) begin
      inc_ones = ones_q + 4'd1;
    end else if (tens_q != 4'd9) begin
      inc_ones = 4'd0;
      inc_tens = tens_q + 4'd1;
    end
  end

  always_comb begin
    dec_tens = tens_q;
    dec_ones = ones_q;
    if (ones_q != 4'd0) begin
      dec_ones = ones_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      lfsr_q    <= SeedEff;
      mole_q    <= 3'd0;
      timer_q   <= 8'd0;
      round_q   <= 8'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      visible_q <= 1'b0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      mole_q    <= mole_d;
      timer_q   <= timer_d;
      round_q   <= round_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      visible_q <= visible_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      over_q    <= over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mole_d  = mole_q;
    timer_d = timer_q;
    round_d = round_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StUp;
          mole_d  = new_mole;
          timer_d = 8'd0;
          round_d = 8'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
        end
      end
      StUp: begin
        // A whack takes priority over a timeout landing in the same cycle.
        if (whack_valid) begin
          timer_d = 8'd0;
          if (whack_pos == mole_q) begin
            state_d = StHit;
            tens_d  = inc_tens;
            ones_d  = inc_ones;
          end else begin
            state_d = StMiss;
`ifdef MISS_PENALTY_EN
            tens_d  = dec_tens;
            ones_d  = dec_ones;
`endif
          end
        end else if (tick) begin
          if (timer_q == MoleLast) begin
            state_d = StMiss;
            timer_d = 8'd0;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
      StHit, StMiss: begin
        if (tick) begin
          if (timer_q == FlashLast) begin
            timer_d = 8'd0;
            round_d = round_q + 8'd1;
            if (round_d == RoundsMax) begin
              state_d = StDone;
            end else begin
              state_d = StUp;
              mole_d  = new_mole;
            end
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    visible_d = (state_d == StUp);
    correct_d = (state_d == StHit);
    wrong_d   = (state_d == StMiss);
    over_d    = (state_d == StDone);
  end

  assign mole_position = mole_q;
  assign mole_visible  = visible_q;
  assign guess_correct = correct_q;
  assign guess_wrong   = wrong_q;
  assign digit_1       = tens_q;
  assign digit_2       = ones_q;
  assign game_over     = over_q;

`ifndef MISS_PENALTY_EN
  logic unused_dec;
  assign unused_dec = ^{dec_tens, dec_ones};
`endif

endmodule

// File: doc/whackamole_game_ctrl.md
Name: whackamole_game_ctrl

Overview:
- Game-logic stage directly upstream of vga_display; replaces the constant mole/score drivers in the Nexys3 top.
- Picks pseudo-random mole holes, times each mole, judges player whacks and keeps a two-digit BCD score.
- Outputs drive vga_display's mole_position, guess_correct, guess_wrong, digit_1 and digit_2.

Parameters:
MOLE_TICKS, 50, ticks a mole stays up before counting as a miss (1..255)
FLASH_TICKS, 10, ticks the hit/miss indication is held (1..255)
ROUNDS, 30, moles per game before game over (1..255)
LFSR_SEED, 8'hA5, LFSR reset value; a value of 0 is replaced by 8'h01

Ports:
clk  in  1  system clock (master_clk domain)
rst  in  1  asynchronous, active-low reset (0 = reset)
tick  in  1  one-cycle game-time enable (e.g. 100 Hz strobe from clocks)
start  in  1  level; begins a new game when in IDLE or DONE
whack_valid  in  1  one-cycle pulse: player struck a hole
whack_pos  in  3  hole struck, valid with whack_valid
mole_position  out  3  current mole hole (0..7)
mole_visible  out  1  high while a mole is up (UP state)
guess_correct  out  1  high throughout a hit flash
guess_wrong  out  1  high throughout a miss flash
digit_1  out  4  score tens, BCD
digit_2  out  4  score ones, BCD
game_over  out  1  high in DONE

Behaviour:
- All outputs registered. Reset (rst=0, async) gives: state IDLE, mole_position 0, mole_visible 0, guess_correct 0, guess_wrong 0, digit_1 0, digit_2 0, game_over 0, timer 0, round count 0, LFSR = LFSR_SEED (or 1).
- Reset is honoured mid-game: every register returns to its reset value immediately.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every clk cycle while out of reset, so player timing adds entropy.
- New mole: candidate = lfsr[2:0]. If the candidate equals the current mole_position, use candidate+1 mod 8 instead, so the same hole never repeats.
- States:
  - IDLE: start=1 -> clear score and round count, load a new mole, timer=0, go to UP.
  - UP: mole_visible=1. The timer increments on each tick.
    - whack_valid with whack_pos==mole_position -> HIT.
    - whack_valid with any other position -> MISS.
    - If no whack and the timer reaches MOLE_TICKS-1 on a tick -> MISS (timeout).
    - If a whack and a timeout occur in the same cycle, the whack wins.
  - HIT: guess_correct=1, mole_visible=0. Score increments (BCD: ones wraps 9->0 with carry into tens); saturates at 99.
  - MISS: guess_wrong=1, mole_visible=0; score unchanged.
  - HIT and MISS each last FLASH_TICKS ticks. Then round count increments:
    - round count == ROUNDS -> DONE;
    - otherwise load a new mole, timer=0, go to UP.
  - DONE: game_over=1, mole_visible=0, score held; start=1 -> same as from IDLE.
- Latency: a whack at cycle N -> guess_* high and score updated at N+1.
- The score/guess change is applied once per mole. whack_valid outside UP is ignored. start outside IDLE/DONE is ignored.
- Holding start across DONE immediately restarts the game; this is intended.

Optional Feature:
MISS_PENALTY_EN:
- Defined: a wrong-position whack decrements the score by 1 in BCD (tens borrow), saturating at 00. Timeouts are not penalised.
- Undefined: a wrong whack leaves the score unchanged.
- guess_wrong behaviour is identical either way.

Test Plan:
- Reset: rst=0 mid-UP -> all outputs 0 immediately. After release with start=0, state stays IDLE and outputs stay 0.
- Hit: start, wait 3 ticks, whack_pos=mole_position -> next cycle guess_correct=1, digit_2=1. After 10 ticks a new mole appears with position != the previous one, and mole_visible=1.
- Wrong whack: whack_pos=mole_position+1 -> guess_wrong=1 for 10 ticks, score 00. With MISS_PENALTY_EN and score 10 -> digit_1=0, digit_2=9.
- Timeout and tie: no whack for 50 ticks -> guess_wrong=1. Correct whack in the same cycle as the 50th tick -> guess_correct=1, guess_wrong=0.
- Saturation/BCD: 9 hits -> 09, 10th -> 10. ROUNDS=120 and 100 hits -> score 99, never wraps.
- Game over: ROUNDS=3, three rounds -> game_over=1, further whacks ignored. start -> score 00, game_over=0, mole_visible=1.
